stack_ctrl: RTL and testbench

Sequencer that owns a 2**D-entry LIFO and serialises single-word stack operations from the core's decode stage: push, pop, peek, dup, swap and clear. It keeps the stack pointer and drives a one-write-port storage array. It also flags overflow and underflow, and exports live top and penultimate values for the ALU operand path.

---
 rtl/stack_pkg.sv | 31 +++
 rtl/stack_mem.sv | 30 +++
 rtl/stack_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stack_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared types and constants for the LIFO stack controller.
//   op_e    - 3-bit opcode carried on stack_ctrl.op
//   state_e - controller FSM states
//   error-precedence constants documenting how competing conditions resolve
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_PEEK  = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5,
    OP_CLEAR = 3'd6,
    OP_ILL   = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } state_e;

  // DUP on an empty stack is reported as underflow even though an empty
  // stack can never also be full; kept explicit so the intent survives if
  // the error flag is ever split into separate overflow/underflow bits.
  localparam bit DUP_UNDERFLOW_FIRST = 1'b1;

  // A new error raised in the same cycle as err_clr keeps err set.
  localparam bit ERR_SET_BEATS_CLR   = 1'b1;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: 2**D x W storage for the stack.
//   clk              - rising-edge clock
//   we/waddr/wdata   - single synchronous write port
//   raddr_a/rdata_a  - asynchronous read port A (top of stack)
//   raddr_b/rdata_b  - asynchronous read port B (penultimate entry)
// The array has no reset; unreachable entries simply hold stale data.
module stack_mem #(
  parameter int W = 8,
  parameter int D = 5
) (
  input  logic         clk,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] raddr_a,
  input  logic [D-1:0] raddr_b,
  output logic [W-1:0] rdata_a,
  output logic [W-1:0] rdata_b
);

  logic [W-1:0] mem [2**D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer for a 2**D-entry LIFO.
//   clk, reset         - clock, synchronous active-high reset
//   op_valid/op_ready  - operation handshake; op, push_data carry the request
//   rsp_valid/rsp_data/rsp_err - registered one-cycle POP/PEEK result
//   top_val/pen_val    - live entries at depth-1 / depth-2 (0 if absent)
//   depth/empty/full   - occupancy
//   err/err_clr        - sticky error flag and its clear
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] push_data,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [W-1:0] top_val,
  output logic [W-1:0] pen_val,
  output logic [D:0]   depth,
  output logic         empty,
  output logic         full,
  output logic         err,
  input  logic         err_clr
);

  localparam logic [D:0] ONE = (D+1)'(1);
  localparam logic [D:0] TWO = (D+1)'(2);
  localparam logic [D:0] CAP = ONE << D;

  state_e       state, state_nxt;
  logic [D:0]   depth_nxt;
  logic [D:0]   dm1, dm2;
  logic [D-1:0] top_idx, pen_idx;
  logic [W-1:0] rd_a, rd_b;
  logic [W-1:0] swap_hold;
  logic         acc;
  op_e          opc;

  logic         we;
  logic [D-1:0] waddr;
  logic [W-1:0] wdata;
  logic         hold_ld;
  logic         rsp_ld;
  logic         rsp_err_nxt;
  logic         err_set;

  assign opc      = op_e'(op);
  assign op_ready = (state == IDLE) && !reset;
  assign acc      = op_valid && op_ready;

  assign empty = (depth == '0);
  assign full  = (depth == CAP);

  // Index arithmetic is D+1 wide; the low D bits address the array.
  // With depth==CAP, depth-1 truncates to the last entry as intended.
  assign dm1     = depth - ONE;
  assign dm2     = depth - TWO;
  assign top_idx = dm1[D-1:0];
  assign pen_idx = dm2[D-1:0];

  assign top_val = (depth >= ONE) ? rd_a : '0;
  assign pen_val = (depth >= TWO) ? rd_b : '0;

  stack_mem #(.W(W), .D(D)) u_mem (
    .clk     (clk),
    .we      (we && !reset),   // reset aborts an in-flight SWAP2 write
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (top_idx),
    .raddr_b (pen_idx),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    state_nxt   = state;
    depth_nxt   = depth;
    we          = 1'b0;
    waddr       = depth[D-1:0];
    wdata       = push_data;
    hold_ld     = 1'b0;
    rsp_ld      = 1'b0;
    rsp_err_nxt = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          case (opc)
            OP_PUSH: begin
              if (full) begin
                err_set = 1'b1;
              end else begin
                we        = 1'b1;
                depth_nxt = depth + ONE;
              end
            end
            OP_POP, OP_PEEK: begin
              rsp_ld = 1'b1;
              if (empty) begin
                rsp_err_nxt = 1'b1;
                err_set     = 1'b1;
              end else if (opc == OP_POP) begin
                depth_nxt = dm1;
              end
            end
            OP_DUP: begin
              if ((DUP_UNDERFLOW_FIRST && empty) || full || empty) begin
                err_set = 1'b1;
              end else begin
                we        = 1'b1;
                wdata     = top_val;
                depth_nxt = depth + ONE;
              end
            end
            OP_SWAP: begin
              if (depth < TWO) begin
                err_set = 1'b1;
              end else begin
                // First half: old pen overwrites top; old top parked.
                we        = 1'b1;
                waddr     = top_idx;
                wdata     = pen_val;
                hold_ld   = 1'b1;
                state_nxt = SWAP2;
              end
            end
            OP_CLEAR: depth_nxt = '0;
            OP_ILL:   err_set   = 1'b1;
            default: ;
          endcase
        end
      end
      SWAP2: begin
        we        = 1'b1;
        waddr     = pen_idx;
        wdata     = swap_hold;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      depth     <= '0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      swap_hold <= '0;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      rsp_valid <= rsp_ld;
      rsp_err   <= rsp_err_nxt;
      rsp_data  <= (rsp_ld && !rsp_err_nxt) ? top_val : '0;
      if (hold_ld) swap_hold <= top_val;
      if (ERR_SET_BEATS_CLR) err <= err_set | (err & ~err_clr);
      else                   err <= (err | err_set) & ~err_clr;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  localparam int W = 8;
  localparam int D = 5;
  localparam int CAPN = 1 << D;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] push_data = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [W-1:0] top_val;
  logic [W-1:0] pen_val;
  logic [D:0]   depth;
  logic         empty;
  logic         full;
  logic         err;
  logic         err_clr = 1'b0;

  stack_ctrl #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .push_data(push_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .top_val(top_val),
    .pen_val(pen_val), .depth(depth), .empty(empty), .full(full),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] stk[$];
  bit           m_busy;     // swap already applied, controller still in its second cycle
  bit           m_rv, m_re, m_err, m_nerr;
  logic [W-1:0] m_rd, m_t;
  int           m_n;

  always @(posedge clk) begin
    if (reset) begin
      stk.delete();
      m_busy = 0; m_rv = 0; m_re = 0; m_rd = '0; m_err = 0;
    end else begin
      m_rv = 0; m_re = 0; m_rd = '0; m_nerr = 0;
      m_n = stk.size();
      if (m_busy) m_busy = 0;
      else if (op_valid) begin
        case (op)
          3'd1: if (m_n == CAPN) m_nerr = 1; else stk.push_back(push_data);
          3'd2, 3'd3: begin
            m_rv = 1;
            if (m_n == 0) begin m_re = 1; m_nerr = 1; end
            else begin
              m_rd = stk[m_n-1];
              if (op == 3'd2) void'(stk.pop_back());
            end
          end
          3'd4: if (m_n == 0 || m_n == CAPN) m_nerr = 1; else stk.push_back(stk[m_n-1]);
          3'd5: if (m_n < 2) m_nerr = 1;
                else begin
                  m_t = stk[m_n-1]; stk[m_n-1] = stk[m_n-2]; stk[m_n-2] = m_t;
                  m_busy = 1;
                end
          3'd6: stk.delete();
          3'd7: m_nerr = 1;
          default: ;
        endcase
      end
      m_err = m_nerr | (m_err & !err_clr);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [W-1:0] e_top, e_pen;
  int           e_n;
  always @(negedge clk) begin
    if (chk_en) begin
      e_n   = stk.size();
      e_top = (e_n >= 1) ? stk[e_n-1] : '0;
      e_pen = m_busy ? e_top : ((e_n >= 2) ? stk[e_n-2] : '0);
      check("depth",     32'(depth),    32'(e_n));
      check("top_val",   32'(top_val),  32'(e_top));
      check("pen_val",   32'(pen_val),  32'(e_pen));
      check("empty",     32'(empty),    32'(e_n == 0));
      check("full",      32'(full),     32'(e_n == CAPN));
      check("op_ready",  32'(op_ready), 32'(!m_busy && !reset));
      check("err",       32'(err),      32'(m_err));
      check("rsp_valid", 32'(rsp_valid),32'(m_rv));
      check("rsp_err",   32'(rsp_err),  32'(m_re));
      check("rsp_data",  32'(rsp_data), 32'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at posedge+1; holds the op until accepted.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d);
    bit acc = 0;
    op_valid = 1'b1; op = o; push_data = d;
    for (int n = 0; n < 8 && !acc; n++) begin
      @(negedge clk); acc = op_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    op_valid = 1'b0; op = 3'd0; push_data = '0;
  endtask

  task automatic idle_cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_err();
    err_clr = 1'b1; idle_cyc(); err_clr = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // pushes
    do_op(3'd1, 8'h11); do_op(3'd1, 8'h22); do_op(3'd1, 8'h33);
    @(negedge clk);
    check("p3_depth", 32'(depth), 32'd3);
    check("p3_top",   32'(top_val), 32'h33);
    check("p3_pen",   32'(pen_val), 32'h22);
    check("p3_empty", 32'(empty), 32'd0);
    idle_cyc();

    // swap then pop
    do_op(3'd5, 8'h00);
    @(negedge clk);
    check("swap_ready_low", 32'(op_ready), 32'd0);
    check("swap_mid_top",   32'(top_val), 32'h22);
    check("swap_mid_pen",   32'(pen_val), 32'h22);
    @(posedge clk); #1;
    do_op(3'd2, 8'h00);
    @(negedge clk);
    check("swpop_rv",    32'(rsp_valid), 32'd1);
    check("swpop_data",  32'(rsp_data), 32'h22);
    check("swpop_top",   32'(top_val), 32'h33);
    check("swpop_depth", 32'(depth), 32'd2);
    idle_cyc();

    // underflow and err_clr collision
    do_op(3'd6, 8'h00);
    do_op(3'd2, 8'h00);
    @(negedge clk);
    check("uf_rv",    32'(rsp_valid), 32'd1);
    check("uf_re",    32'(rsp_err), 32'd1);
    check("uf_data",  32'(rsp_data), 32'd0);
    check("uf_err",   32'(err), 32'd1);
    check("uf_depth", 32'(depth), 32'd0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    do_op(3'd2, 8'h00);
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_vs_set_err", 32'(err), 32'd1);
    @(posedge clk); #1;
    clr_err();
    @(negedge clk);
    check("clr_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // fill and overflow
    for (int i = 0; i < CAPN; i++) do_op(3'd1, W'(i));
    do_op(3'd1, 8'hAA);
    do_op(3'd4, 8'h00);
    @(negedge clk);
    check("of_full",  32'(full), 32'd1);
    check("of_depth", 32'(depth), 32'd32);
    check("of_err",   32'(err), 32'd1);
    check("of_top",   32'(top_val), 32'h1F);
    @(posedge clk); #1;

    // peek and dup
    do_op(3'd6, 8'h00);
    clr_err();
    do_op(3'd1, 8'h5C);
    do_op(3'd3, 8'h00);
    @(negedge clk);
    check("pk_data",  32'(rsp_data), 32'h5C);
    check("pk_depth", 32'(depth), 32'd1);
    @(posedge clk); #1;
    do_op(3'd4, 8'h00);
    @(negedge clk);
    check("dup_depth", 32'(depth), 32'd2);
    check("dup_top",   32'(top_val), 32'h5C);
    check("dup_pen",   32'(pen_val), 32'h5C);
    @(posedge clk); #1;

    // reset during SWAP2
    do_op(3'd1, 8'h01); do_op(3'd1, 8'h02);
    do_op(3'd5, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rs_depth", 32'(depth), 32'd0);
    check("rs_ready", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    do_op(3'd6, 8'h00);
    @(negedge clk);
    check("clear_no_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    do_op(3'd7, 8'h00);
    @(negedge clk);
    check("ill_err", 32'(err), 32'd1);
    @(posedge clk); #1;
    // afterwards the pushes land on a fresh stack
    do_op(3'd1, 8'h77);
    @(negedge clk);
    check("post_top", 32'(top_val), 32'h77);
    @(posedge clk); #1;

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
